sysid_uptime: RTL

SYSID_UPTIME -- requirements
Module: sysid_uptime

---
 rtl/sysid_uptime.sv | 109 ++++++++++
 1 files changed

// File: rtl/sysid_uptime.sv
// System identification and uptime block: read-only build constants, a free-running
// 64-bit cycle counter with a high-word snapshot, a seconds counter, and a scratch register.
module sysid_uptime #(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
  parameter logic [31:0] CLK_FREQ_HZ     = 32'd50000000,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_FREQ    = 3'd2;
  localparam logic [2:0] ADDR_SECONDS = 3'd3;
  localparam logic [2:0] ADDR_CNT_LO  = 3'd4;
  localparam logic [2:0] ADDR_CNT_HI  = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;
  localparam logic [2:0] ADDR_CTRL    = 3'd7;

  logic [63:0] cycle_cnt;
  logic [31:0] prescaler;
  logic [31:0] seconds;
  logic [31:0] snapshot;
  logic [31:0] scratch;
  logic [31:0] rd_mux;

  // Handshake: no waitrequest, every accepted read returns exactly one cycle later
  // with a one-cycle readdatavalid pulse; a write in the same cycle wins and drops the read.
  logic rd_accept;
  logic wr_accept;
  logic clear;
  logic presc_tc;

  assign rd_accept = chipselect && read && !write;
  assign wr_accept = chipselect && write;
  assign clear     = wr_accept && (address == ADDR_CTRL) && writedata[0];
  assign presc_tc  = (prescaler == CLK_FREQ_HZ - 32'd1);

  always_comb begin
    rd_mux = 32'h0000_0000;
    case (address)
      ADDR_ID:      rd_mux = ID_VALUE;
      ADDR_TS:      rd_mux = TIMESTAMP_VALUE;
      ADDR_FREQ:    rd_mux = CLK_FREQ_HZ;
      ADDR_SECONDS: rd_mux = seconds;
      ADDR_CNT_LO:  rd_mux = cycle_cnt[31:0];
      ADDR_CNT_HI:  rd_mux = snapshot;
      ADDR_SCRATCH: rd_mux = scratch;
      default:      rd_mux = 32'h0000_0000;
    endcase
  end

  // Counters and snapshot; a clear takes priority over counting at the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= 64'd0;
      prescaler <= 32'd0;
      seconds   <= 32'd0;
      snapshot  <= 32'd0;
    end else if (clear) begin
      cycle_cnt <= 64'd0;
      prescaler <= 32'd0;
      seconds   <= 32'd0;
      snapshot  <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (presc_tc) begin
        prescaler <= 32'd0;
        seconds   <= seconds + 32'd1;
      end else begin
        prescaler <= prescaler + 32'd1;
      end
      // Latch the high word with the low-word read so the 64-bit value is coherent.
      if (rd_accept && (address == ADDR_CNT_LO)) begin
        snapshot <= cycle_cnt[63:32];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
    end else if (wr_accept && (address == ADDR_SCRATCH)) begin
      scratch <= writedata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0000_0000;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_accept;
      if (rd_accept) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule
